// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI4-Lite master.
// A simple cmd/rsp pair is turned into one AXI4-Lite read or write. Only
// one transaction is in flight at a time. Every output comes from a flop.
module axil_master #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] WR_RESP      = 3'd2;
  localparam logic [2:0] RD_ADDR      = 3'd3;
  localparam logic [2:0] RD_DATA      = 3'd4;
  localparam logic [2:0] RESP         = 3'd5;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  aw_done;
  logic                  w_done;

  // AW and AR never run at the same time, so one word-aligned address
  // register feeds both channels.
  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;

  // A channel counts as finished if it already retired or retires this edge.
  assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

  // Transaction sequencer: every output is a registered function of state.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      addr          <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            addr        <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            M_AXI_WDATA <= cmd_wdata;
            M_AXI_WSTRB <= cmd_wstrb;
            if (cmd_write) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_ADDR_DATA;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            M_AXI_RREADY <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          // cmd_ready comes back only after the response is taken, so a
          // new command can never overlap the handshake cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: randomized bench for axil_master with a memory-backed
// AXI4-Lite slave whose ready/valid latencies and response codes are set
// per transaction, a protocol monitor, and a plain word-array reference.
module tb_axil_master;

  logic        M_AXI_ACLK = 1'b0;
  logic        M_AXI_ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int checks = 0;
  int failures = 0;

  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  axil_master #(.ADDR_WIDTH(4)) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESETN(M_AXI_ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model ----------------
  int aw_delay, w_delay, b_delay, ar_delay, r_delay;
  logic [1:0] bresp_cfg, rresp_cfg;
  logic [31:0] smem [4];
  logic [31:0] ref_mem [4];
  logic aw_got, w_got, ar_got;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [3:0]  sl_awaddr, sl_araddr, sl_wstrb;
  logic [31:0] sl_wdata;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Slave: each READY rises after its configured wait, drops on handshake.
  always @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      M_AXI_AWREADY <= 0; M_AXI_WREADY <= 0; M_AXI_BVALID <= 0;
      M_AXI_BRESP <= 0; M_AXI_ARREADY <= 0; M_AXI_RVALID <= 0;
      M_AXI_RDATA <= 0; M_AXI_RRESP <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_got <= 1; M_AXI_AWREADY <= 0; sl_awaddr <= M_AXI_AWADDR;
      end else if (M_AXI_AWVALID && !aw_got) begin
        if (aw_cnt >= aw_delay) M_AXI_AWREADY <= 1;
        aw_cnt <= aw_cnt + 1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_got <= 1; M_AXI_WREADY <= 0;
        sl_wdata <= M_AXI_WDATA; sl_wstrb <= M_AXI_WSTRB;
      end else if (M_AXI_WVALID && !w_got) begin
        if (w_cnt >= w_delay) M_AXI_WREADY <= 1;
        w_cnt <= w_cnt + 1;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        M_AXI_BVALID <= 0; aw_got <= 0; w_got <= 0;
        aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      end else if (aw_got && w_got && !M_AXI_BVALID) begin
        if (b_cnt >= b_delay) begin
          M_AXI_BVALID <= 1; M_AXI_BRESP <= bresp_cfg;
          smem[sl_awaddr[3:2]] <= merge(smem[sl_awaddr[3:2]], sl_wdata, sl_wstrb);
        end else b_cnt <= b_cnt + 1;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_got <= 1; M_AXI_ARREADY <= 0; sl_araddr <= M_AXI_ARADDR;
      end else if (M_AXI_ARVALID && !ar_got) begin
        if (ar_cnt >= ar_delay) M_AXI_ARREADY <= 1;
        ar_cnt <= ar_cnt + 1;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        M_AXI_RVALID <= 0; ar_got <= 0; ar_cnt <= 0; r_cnt <= 0;
      end else if (ar_got && !M_AXI_RVALID) begin
        if (r_cnt >= r_delay) begin
          M_AXI_RVALID <= 1; M_AXI_RRESP <= rresp_cfg;
          M_AXI_RDATA <= smem[sl_araddr[3:2]];
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // Handshake counters, kept across resets.
  always @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESETN) begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) n_aw <= n_aw + 1;
      if (M_AXI_WVALID && M_AXI_WREADY)   n_w  <= n_w + 1;
      if (M_AXI_BVALID && M_AXI_BREADY)   n_b  <= n_b + 1;
      if (M_AXI_ARVALID && M_AXI_ARREADY) n_ar <= n_ar + 1;
      if (M_AXI_RVALID && M_AXI_RREADY)   n_r  <= n_r + 1;
    end
  end

  // ---------------- protocol monitor ----------------
  int viol = 0;
  logic split_seen = 0;
  logic p_aw, p_awr, p_w, p_wr, p_ar, p_arr, p_rv, p_rr;
  logic [3:0] p_awaddr, p_araddr, p_wstrb;
  logic [31:0] p_wdata, p_rdata;

  // Flags a VALID that drops early or payload that moves before handshake.
  always @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      p_aw <= 0; p_w <= 0; p_ar <= 0; p_rv <= 0;
      p_awr <= 0; p_wr <= 0; p_arr <= 0; p_rr <= 0;
    end else begin
      if (p_aw && !p_awr && (!M_AXI_AWVALID || M_AXI_AWADDR != p_awaddr)) viol <= viol + 1;
      if (p_w && !p_wr && (!M_AXI_WVALID || M_AXI_WDATA != p_wdata ||
                           M_AXI_WSTRB != p_wstrb)) viol <= viol + 1;
      if (p_ar && !p_arr && (!M_AXI_ARVALID || M_AXI_ARADDR != p_araddr)) viol <= viol + 1;
      if (p_rv && !p_rr && (!rsp_valid || rsp_rdata != p_rdata)) viol <= viol + 1;
      if (M_AXI_BREADY && M_AXI_RREADY) viol <= viol + 1;
      if (M_AXI_AWVALID && !M_AXI_WVALID) split_seen <= 1;
      p_aw <= M_AXI_AWVALID; p_awr <= M_AXI_AWREADY; p_awaddr <= M_AXI_AWADDR;
      p_w <= M_AXI_WVALID; p_wr <= M_AXI_WREADY; p_wdata <= M_AXI_WDATA;
      p_wstrb <= M_AXI_WSTRB;
      p_ar <= M_AXI_ARVALID; p_arr <= M_AXI_ARREADY; p_araddr <= M_AXI_ARADDR;
      p_rv <= rsp_valid; p_rr <= rsp_ready; p_rdata <= rsp_rdata;
    end
  end

  // ---------------- drivers ----------------
  // Issue one command; returns at a falling edge with rsp_valid still high.
  task automatic issue(input bit wr, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output bit to);
    int n;
    to = 0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge M_AXI_ACLK); n++; end
    if (!cmd_ready) begin to = 1; return; end
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge M_AXI_ACLK);
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 4'($urandom);
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge M_AXI_ACLK); n++; end
    if (!rsp_valid) to = 1;
  endtask

  task automatic consume();
    rsp_ready = 1;
    @(negedge M_AXI_ACLK);
    rsp_ready = 0;
  endtask

  task automatic set_lat(input int aw, input int w, input int b,
                         input int ar, input int r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  task automatic timeout_fail(input string name);
    checks++; failures++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_hs: cmd_ready=%b rsp_valid=%b want 0 0", cmd_ready, rsp_valid);
    end
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      failures++; $display("FAIL reset_valids: got %b want 00000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b0 || M_AXI_AWADDR !== 4'h0 ||
        M_AXI_ARADDR !== 4'h0 || M_AXI_WDATA !== 32'h0 || M_AXI_WSTRB !== 4'h0) begin
      failures++; $display("FAIL reset_data: rdata=%h resp=%b awaddr=%h wdata=%h want zeros",
        rsp_rdata, rsp_resp, M_AXI_AWADDR, M_AXI_WDATA);
    end
    M_AXI_ARESETN = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL reset_release: cmd_ready=%b want 0 before edge", cmd_ready);
    end
    @(negedge M_AXI_ACLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_first_edge: cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_basic();
    bit to;
    set_lat(1, 1, 0, 0, 0); bresp_cfg = 0; rresp_cfg = 0;
    issue(1, 4'h4, 32'h3F800000, 4'hF, to);
    if (to) begin timeout_fail("write_basic"); return; end
    ref_mem[1] = merge(ref_mem[1], 32'h3F800000, 4'hF);
    checks++;
    if (sl_awaddr !== 4'h4 || sl_wdata !== 32'h3F800000 || sl_wstrb !== 4'hF) begin
      failures++; $display("FAIL write_bus: awaddr=%h wdata=%h wstrb=%h want 4 3f800000 f",
        sl_awaddr, sl_wdata, sl_wstrb);
    end
    checks++;
    if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL write_rsp: resp=%b rdata=%h want 00 0", rsp_resp, rsp_rdata);
    end
    consume();
    issue(0, 4'h4, 32'h0, 4'h0, to);
    if (to) begin timeout_fail("write_readback"); return; end
    checks++;
    if (rsp_rdata !== 32'h3F800000 || rsp_resp !== 2'b00) begin
      failures++; $display("FAIL write_readback: rdata=%h resp=%b want 3f800000 00", rsp_rdata, rsp_resp);
    end
    consume();
  endtask

  task automatic test_split_write();
    bit to;
    int aw0, w0, b0;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    split_seen = 0;
    set_lat(3, 0, 1, 0, 0); bresp_cfg = 0;
    issue(1, 4'h8, 32'hCAFEF00D, 4'h5, to);
    if (to) begin timeout_fail("split_write"); return; end
    ref_mem[2] = merge(ref_mem[2], 32'hCAFEF00D, 4'h5);
    checks++;
    if (n_aw - aw0 != 1 || n_w - w0 != 1 || n_b - b0 != 1) begin
      failures++; $display("FAIL split_counts: aw=%0d w=%0d b=%0d want 1 1 1",
        n_aw - aw0, n_w - w0, n_b - b0);
    end
    checks++;
    if (split_seen !== 1'b1) begin
      failures++; $display("FAIL split_order: awvalid-alone seen=%b want 1", split_seen);
    end
    checks++;
    if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL split_rsp: resp=%b rdata=%h want 00 0", rsp_resp, rsp_rdata);
    end
    consume();
    repeat (3) @(negedge M_AXI_ACLK);
    checks++;
    if (n_b - b0 != 1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL split_single: b=%0d rsp_valid=%b want 1 0", n_b - b0, rsp_valid);
    end
  endtask

  task automatic test_read_align();
    bit to;
    set_lat(0, 0, 0, 1, 2); bresp_cfg = 0; rresp_cfg = 0;
    issue(1, 4'hC, 32'h00003A5C, 4'hF, to);
    if (to) begin timeout_fail("read_setup"); return; end
    ref_mem[3] = merge(ref_mem[3], 32'h00003A5C, 4'hF);
    consume();
    issue(0, 4'hE, 32'h0, 4'h0, to);
    if (to) begin timeout_fail("read_align"); return; end
    checks++;
    if (sl_araddr !== 4'hC) begin
      failures++; $display("FAIL read_araddr: got %h want c", sl_araddr);
    end
    checks++;
    if (rsp_rdata !== 32'h00003A5C || rsp_resp !== 2'b00) begin
      failures++; $display("FAIL read_data: rdata=%h resp=%b want 00003a5c 00", rsp_rdata, rsp_resp);
    end
    consume();
  endtask

  task automatic test_rsp_hold();
    bit to;
    bit bad;
    int ar0;
    logic [31:0] held;
    set_lat(0, 0, 0, 0, 1); rresp_cfg = 0;
    issue(0, 4'h4, 32'h0, 4'h0, to);
    if (to) begin timeout_fail("rsp_hold"); return; end
    held = rsp_rdata;
    ar0 = n_ar;
    bad = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h8;
    repeat (5) begin
      @(negedge M_AXI_ACLK);
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || cmd_ready !== 1'b0) bad = 1;
    end
    cmd_valid = 0;
    checks++;
    if (bad || held !== ref_mem[1]) begin
      failures++; $display("FAIL rsp_hold: rsp_valid=%b rdata=%h cmd_ready=%b want 1 %h 0",
        rsp_valid, rsp_rdata, cmd_ready, ref_mem[1]);
    end
    checks++;
    if (n_ar != ar0) begin
      failures++; $display("FAIL hold_ignore: ar handshakes=%0d want 0", n_ar - ar0);
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_bresp_err();
    bit to;
    int b0;
    b0 = n_b;
    set_lat(0, 1, 2, 0, 0); bresp_cfg = 2'b10;
    issue(1, 4'h0, 32'h12345678, 4'h3, to);
    if (to) begin timeout_fail("bresp_err"); return; end
    ref_mem[0] = merge(ref_mem[0], 32'h12345678, 4'h3);
    checks++;
    if (rsp_resp !== 2'b10 || rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL bresp_err: resp=%b rdata=%h want 10 0", rsp_resp, rsp_rdata);
    end
    consume();
    repeat (3) @(negedge M_AXI_ACLK);
    checks++;
    if (n_b - b0 != 1) begin
      failures++; $display("FAIL bresp_retry: b handshakes=%0d want 1", n_b - b0);
    end
    bresp_cfg = 0;
    issue(0, 4'h0, 32'h0, 4'h0, to);
    if (to) begin timeout_fail("bresp_next"); return; end
    checks++;
    if (rsp_rdata !== ref_mem[0] || rsp_resp !== 2'b00) begin
      failures++; $display("FAIL bresp_next: rdata=%h resp=%b want %h 00", rsp_rdata, rsp_resp, ref_mem[0]);
    end
    consume();
  endtask

  task automatic test_random();
    bit to;
    bit wr;
    logic [3:0] a, s;
    logic [31:0] d, exp_d;
    logic [1:0] exp_r;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); a = 4'($urandom); d = $urandom; s = 4'($urandom);
      set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      bresp_cfg = 2'($urandom); rresp_cfg = 2'($urandom);
      issue(wr, a, d, s, to);
      if (to) begin timeout_fail("random"); return; end
      if (wr) begin
        ref_mem[a[3:2]] = merge(ref_mem[a[3:2]], d, s);
        exp_d = 32'h0; exp_r = bresp_cfg;
      end else begin
        exp_d = ref_mem[a[3:2]]; exp_r = rresp_cfg;
      end
      checks++;
      if (rsp_rdata !== exp_d || rsp_resp !== exp_r) begin
        failures++; $display("FAIL random[%0d] wr=%b addr=%h: rdata=%h resp=%b want %h %b",
          i, wr, a, rsp_rdata, rsp_resp, exp_d, exp_r);
      end
      repeat ($urandom_range(0, 2)) @(negedge M_AXI_ACLK);
      consume();
    end
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL protocol: violations=%0d want 0", viol);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit stale;
    int n;
    set_lat(0, 0, 0, 20, 0); rresp_cfg = 0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge M_AXI_ACLK); n++; end
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h8;
    @(negedge M_AXI_ACLK);
    cmd_valid = 0;
    repeat (2) @(negedge M_AXI_ACLK);
    checks++;
    if (M_AXI_ARVALID !== 1'b1) begin
      failures++; $display("FAIL mid_arvalid: got %b want 1", M_AXI_ARVALID);
    end
    #2 M_AXI_ARESETN = 0;
    #1;
    checks++;
    if (M_AXI_ARVALID !== 1'b0 || M_AXI_RREADY !== 1'b0 || rsp_valid !== 1'b0 ||
        cmd_ready !== 1'b0) begin
      failures++; $display("FAIL mid_async: arvalid=%b rready=%b rsp_valid=%b cmd_ready=%b want 0000",
        M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready);
    end
    @(negedge M_AXI_ACLK);
    M_AXI_ARESETN = 1;
    @(negedge M_AXI_ACLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL mid_release: cmd_ready=%b want 1", cmd_ready);
    end
    stale = 0;
    repeat (6) begin
      if (rsp_valid !== 1'b0 || M_AXI_ARVALID !== 1'b0) stale = 1;
      @(negedge M_AXI_ACLK);
    end
    checks++;
    if (stale) begin
      failures++; $display("FAIL mid_stale: response or ARVALID after reset, want none");
    end
    set_lat(0, 0, 0, 1, 1);
    issue(0, 4'h8, 32'h0, 4'h0, to);
    if (to) begin timeout_fail("mid_recover"); return; end
    checks++;
    if (rsp_rdata !== ref_mem[2]) begin
      failures++; $display("FAIL mid_recover: rdata=%h want %h", rsp_rdata, ref_mem[2]);
    end
    consume();
  endtask

  initial begin
    M_AXI_ARESETN = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    set_lat(0, 0, 0, 0, 0); bresp_cfg = 0; rresp_cfg = 0;
    for (int i = 0; i < 4; i++) begin
      smem[i] = $urandom; ref_mem[i] = smem[i];
    end
    repeat (3) @(negedge M_AXI_ACLK);
    test_reset();
    test_write_basic();
    test_split_write();
    test_read_align();
    test_rsp_hold();
    test_bresp_err();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_master.md
Name:
axil_master

Overview:
- Single-outstanding AXI4-Lite master that turns simple command/response transactions into AXI4-Lite reads and writes.
- Drives the CORDIC AXI4-Lite slave register map from a local controller or testbench: ctrl 0x0, angle 0x4, cos 0x8, sin 0xC.
- Data width is fixed at 32 bits; no burst or outstanding-transaction support.

Parameters:
ADDR_WIDTH, 4, byte-address width of AW/AR and cmd_addr

Ports:
M_AXI_ACLK  in  1  clock, all logic rising-edge
M_AXI_ARESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  master idle, command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  32  write data
cmd_wstrb  in  4  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  32  read data; 0 for writes
rsp_resp  out  2  BRESP or RRESP of the transaction
M_AXI_AWADDR  out  ADDR_WIDTH  write address
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  write strobes
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  ADDR_WIDTH  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready

Behaviour:
- Reset (async, while ARESETN=0):
  - All VALID/READY outputs, cmd_ready and rsp_valid are 0; rsp_rdata=0, rsp_resp=0; state IDLE.
  - All address/data outputs are 0.
  - cmd_ready rises on the first clock edge after reset release.
- Reset mid-operation: all VALIDs drop immediately and the transaction is abandoned; no response is issued.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On accept: register addr with bits [1:0] forced to 0, wdata, wstrb; cmd_ready goes 0 the next cycle.
  - Write: AWVALID=WVALID=1 from the next cycle.
  - Read: ARVALID=1 from the next cycle.
- WR_ADDR_DATA:
  - AWVALID and WVALID retire independently; each clears the cycle after its own READY is sampled with VALID high.
  - Both handshakes in the same cycle is legal.
  - AWADDR/WDATA/WSTRB stay stable while the corresponding VALID is high.
  - When both have completed, go to WR_RESP with BREADY=1 the next cycle.
- WR_RESP: on BVALID && BREADY, capture BRESP into rsp_resp, clear rsp_rdata, deassert BREADY, go to RESP.
- RD_ADDR: ARVALID holds until ARREADY is sampled; then ARVALID=0, RREADY=1, go to RD_DATA.
- RD_DATA: on RVALID && RREADY, capture RDATA/RRESP, RREADY=0, go to RESP.
- RESP:
  - rsp_valid=1, with data held stable until rsp_ready.
  - On handshake: rsp_valid=0 and cmd_ready=1 the next cycle (back to IDLE). A new command cannot be accepted in the handshake cycle.
- Responses: non-OKAY responses (01/10/11) are passed through unchanged; no retry.
- VALID rules: a VALID never drops before its handshake; BREADY/RREADY are high only in their wait states.
- Concurrency: only one transaction is in flight at a time; cmd inputs are ignored outside IDLE.

Test Plan:
- Write 0x3F800000 to 0x4 with wstrb=0xF, slave asserts AWREADY and WREADY together after 1 cycle -> bus shows AWADDR=0x4, WDATA=0x3F800000; rsp_valid with rsp_resp=00, rsp_rdata=0; readback of 0x4 returns 0x3F800000.
- Slave asserts WREADY 3 cycles before AWREADY -> WVALID clears after its handshake, AWVALID persists with AWADDR stable; exactly one B handshake; one response.
- Read 0xC, slave RVALID with RDATA=0x00003A5C, RRESP=00 -> rsp_rdata=0x00003A5C, rsp_resp=00; cmd_addr=0xE is issued as ARADDR=0xC.
- rsp_ready held 0 for 5 cycles after a read -> rsp_valid stays 1 with rsp_rdata unchanged; cmd_ready stays 0; a new command is accepted only after the handshake.
- Slave returns BRESP=10 -> rsp_resp=10, no retry; next command proceeds normally.
- Deassert ARESETN while ARVALID=1 -> ARVALID, RREADY and rsp_valid go 0 asynchronously; after release, no stale response and cmd_ready=1 after one edge.
